// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for a 32-entry register file. Each requester
// owns a one-entry buffer; same-address entries drain oldest first, otherwise round-robin.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wb0_valid,
    output logic                  wb0_ready,
    input  logic [ADDR_WIDTH-1:0] wb0_address,
    input  logic [DATA_WIDTH-1:0] wb0_data,
    input  logic                  wb1_valid,
    output logic                  wb1_ready,
    input  logic [ADDR_WIDTH-1:0] wb1_address,
    input  logic [DATA_WIDTH-1:0] wb1_data,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [31:0]           busy_mask,
    output logic [15:0]           conflict_count
);

    logic [1:0]            buf_valid;
    logic [1:0]            buf_age;      // bit k set: entry k is the older one
    logic [ADDR_WIDTH-1:0] buf_addr [2];
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  prio;

    logic [ADDR_WIDTH-1:0] in_addr  [2];
    logic [DATA_WIDTH-1:0] in_data  [2];
    logic [1:0]            in_valid;
    logic [1:0]            grant;
    logic [1:0]            ready;
    logic [1:0]            load;
    logic [1:0]            stays;

    assign in_valid   = {wb1_valid, wb0_valid};
    assign in_addr[0] = wb0_address;
    assign in_addr[1] = wb1_address;
    assign in_data[0] = wb0_data;
    assign in_data[1] = wb1_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant = buf_valid;
        if (buf_valid == 2'b11) begin
            if (buf_addr[0] == buf_addr[1])
                grant = buf_age[0] ? 2'b01 : 2'b10;
            else
                grant = prio ? 2'b10 : 2'b01;
        end
    end

    // Ready depends only on buffer state, never on the requester's valid.
    always_comb begin
        ready = ~buf_valid | grant;
        stays = buf_valid & ~grant;
        for (int k = 0; k < 2; k++)
            load[k] = in_valid[k] && ready[k] && (in_addr[k] != '0);
    end

    assign wb0_ready = ready[0];
    assign wb1_ready = ready[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid      <= 2'b00;
            buf_age        <= 2'b00;
            prio           <= 1'b0;
            conflict_count <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (load[k])
                    buf_valid[k] <= 1'b1;
                else if (grant[k])
                    buf_valid[k] <= 1'b0;
            end
            // A fresh entry is younger than whatever survives in the other buffer.
            case (load)
                2'b11:   buf_age <= 2'b01;
                2'b01:   buf_age <= stays[1] ? 2'b10 : 2'b01;
                2'b10:   buf_age <= stays[0] ? 2'b01 : 2'b10;
                default: ;
            endcase
            if (grant[0])
                prio <= 1'b1;
            else if (grant[1])
                prio <= 1'b0;
            if (buf_valid == 2'b11 && conflict_count != 16'hFFFF)
                conflict_count <= conflict_count + 16'd1;
        end
    end

    // NOTE: buffer payload is not reset; it is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (load[k]) begin
                buf_addr[k] <= in_addr[k];
                buf_data[k] <= in_data[k];
            end
        end
    end

    always_comb begin
        write_enable  = |buf_valid;
        write_address = '0;
        write_data    = '0;
        if (grant[0]) begin
            write_address = buf_addr[0];
            write_data    = buf_data[0];
        end else if (grant[1]) begin
            write_address = buf_addr[1];
            write_data    = buf_data[1];
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < 32; r++) begin
            busy_mask[r] = (buf_valid[0] && buf_addr[0] == ADDR_WIDTH'(r))
                        || (buf_valid[1] && buf_addr[1] == ADDR_WIDTH'(r));
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, streaming, mid-flight reset,
// and randomized traffic against a sequence-number reference model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic        wb0_ready, wb1_ready;
    logic [4:0]  wb0_address = '0, wb1_address = '0;
    logic [31:0] wb0_data = '0, wb1_data = '0;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [31:0] busy_mask;
    logic [15:0] conflict_count;

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready),
        .wb0_address(wb0_address), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready),
        .wb1_address(wb1_address), .wb1_data(wb1_data),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .busy_mask(busy_mask),
        .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wb0_valid = 1'b0; wb0_address = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_address = '0; wb1_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        v0; logic [4:0] a0; logic [31:0] d0;
        logic        v1; logic [4:0] a1; logic [31:0] d1;
        logic        e_we; logic [4:0] e_addr; logic [31:0] e_data;
        logic [31:0] e_busy; logic e_r0; logic e_r1; logic [15:0] e_cc;
    } vec_t;

    vec_t tbl [15];

    // Reference model: pending entries ordered by a global acceptance sequence number.
    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        int unsigned seq;
    } ent_t;

    ent_t        pend [2];
    bit          m_prio;
    int          m_cc;
    int unsigned seq_ctr;
    logic [31:0] last_val [32];
    logic [31:0] dut_rf   [32];

    function automatic int model_grant();
        if (pend[0].v && pend[1].v) begin
            if (pend[0].a == pend[1].a)
                return (pend[0].seq < pend[1].seq) ? 0 : 1;
            return m_prio ? 1 : 0;
        end
        if (pend[0].v) return 0;
        if (pend[1].v) return 1;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: wb0 {v,a,d}, wb1 {v,a,d}, expected {we,addr,data,busy,r0,r1,cc} before drive.
        tbl[0]  = '{1, 3, 32'hA,        1, 4, 32'hB,  0, 0, 32'h0,    32'h0,   1, 1, 0};
        tbl[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 3, 32'hA,    32'h18,  1, 0, 0};
        tbl[2]  = '{1, 5, 32'h1234,     0, 0, 32'h0,  1, 4, 32'hB,    32'h10,  1, 1, 1};
        tbl[3]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,  1, 5, 32'h1234, 32'h20,  1, 1, 1};
        tbl[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,    32'h0,   1, 1, 1};
        tbl[5]  = '{0, 0, 32'h0,        1, 9, 32'h99, 0, 0, 32'h0,    32'h0,   1, 1, 1};
        tbl[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 9, 32'h99,   32'h200, 1, 1, 1};
        tbl[7]  = '{1, 6, 32'h66,       1, 7, 32'h1,  0, 0, 32'h0,    32'h0,   1, 1, 1};
        tbl[8]  = '{1, 7, 32'h2,        0, 0, 32'h0,  1, 6, 32'h66,   32'hC0,  1, 0, 1};
        tbl[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 7, 32'h1,    32'h80,  0, 1, 2};
        tbl[10] = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 7, 32'h2,    32'h80,  1, 1, 3};
        tbl[11] = '{1, 8, 32'h80,       1, 8, 32'h81, 0, 0, 32'h0,    32'h0,   1, 1, 3};
        tbl[12] = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 8, 32'h80,   32'h100, 1, 0, 3};
        tbl[13] = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 8, 32'h81,   32'h100, 1, 1, 4};
        tbl[14] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,    32'h0,   1, 1, 4};

        // ---------------- directed table ----------------
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("tbl%0d_we", i),   write_enable,   tbl[i].e_we);
            check($sformatf("tbl%0d_addr", i), write_address,  tbl[i].e_addr);
            check($sformatf("tbl%0d_data", i), write_data,     tbl[i].e_data);
            check($sformatf("tbl%0d_busy", i), busy_mask,      tbl[i].e_busy);
            check($sformatf("tbl%0d_r0", i),   wb0_ready,      tbl[i].e_r0);
            check($sformatf("tbl%0d_r1", i),   wb1_ready,      tbl[i].e_r1);
            check($sformatf("tbl%0d_cc", i),   conflict_count, tbl[i].e_cc);
            wb0_valid = tbl[i].v0; wb0_address = tbl[i].a0; wb0_data = tbl[i].d0;
            wb1_valid = tbl[i].v1; wb1_address = tbl[i].a1; wb1_data = tbl[i].d1;
        end
        idle_inputs();

        // ---------------- streaming: 100 entries per requester ----------------
        begin
            int          n0 = 0, n1 = 0, writes = 0, first_c = -1, last_c = -1;
            int          alt_bad = 0, order_bad = 0;
            bit          done = 0;
            bit          have_prev = 0;
            logic        prev_src = 1'b0;
            logic [31:0] q0 [$];
            logic [31:0] q1 [$];
            do_reset();
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (write_enable) begin
                    writes++;
                    if (first_c < 0) first_c = c;
                    last_c = c;
                    if (have_prev && n0 < 100 && n1 < 100 && write_data[31] == prev_src)
                        alt_bad++;
                    prev_src  = write_data[31];
                    have_prev = 1;
                    if (write_data[31]) q1.push_back({1'b0, write_data[30:0]});
                    else                q0.push_back({1'b0, write_data[30:0]});
                end else if (n0 == 100 && n1 == 100) begin
                    done = 1;
                    break;
                end
                wb0_valid   = (n0 < 100);
                wb0_address = 5'(1 + n0 % 15);
                wb0_data    = {1'b0, 31'(n0)};
                wb1_valid   = (n1 < 100);
                wb1_address = 5'(16 + n1 % 15);
                wb1_data    = {1'b1, 31'(n1)};
                if (wb0_valid && wb0_ready) n0++;
                if (wb1_valid && wb1_ready) n1++;
            end
            idle_inputs();
            check("stream_done", 32'(done), 32'd1);
            check("stream_q0_size", q0.size(), 32'd100);
            check("stream_q1_size", q1.size(), 32'd100);
            for (int i = 0; i < q0.size(); i++) if (q0[i] != 32'(i)) order_bad++;
            for (int i = 0; i < q1.size(); i++) if (q1[i] != 32'(i)) order_bad++;
            check("stream_order", order_bad, 32'd0);
            check("stream_no_gaps", last_c - first_c + 1, writes);
            check("stream_alternate", alt_bad, 32'd0);
        end

        // ---------------- reset mid-flight ----------------
        do_reset();
        @(negedge clk);
        wb0_valid = 1; wb0_address = 10; wb0_data = 32'hA0;
        wb1_valid = 1; wb1_address = 11; wb1_data = 32'hB0;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        wb0_valid = 1; wb0_address = 12; wb0_data = 32'hA1;
        wb1_valid = 1; wb1_address = 13; wb1_data = 32'hB1;
        @(negedge clk);
        idle_inputs();
        check("rst_pre_busy", busy_mask, 32'h3000);
        check("rst_pre_cc", conflict_count, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_we",   write_enable,   32'd0);
        check("rst_addr", write_address,  32'd0);
        check("rst_data", write_data,     32'd0);
        check("rst_busy", busy_mask,      32'd0);
        check("rst_r0",   wb0_ready,      32'd1);
        check("rst_r1",   wb1_ready,      32'd1);
        check("rst_cc",   conflict_count, 32'd0);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_after%0d_we", c), write_enable, 32'd0);
        end

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        pend[0] = '{0, 0, 0, 0};
        pend[1] = '{0, 0, 0, 0};
        m_prio  = 0;
        m_cc    = 0;
        seq_ctr = 0;
        for (int r = 0; r < 32; r++) begin
            last_val[r] = '0;
            dut_rf[r]   = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            int          g;
            logic [31:0] e_busy;
            logic        m_r0, m_r1, dv0, dv1;
            logic [4:0]  da0, da1;
            logic [31:0] dd0, dd1;
            @(negedge clk);
            g = model_grant();
            e_busy = '0;
            for (int k = 0; k < 2; k++)
                if (pend[k].v) e_busy = e_busy | (32'd1 << pend[k].a);
            m_r0 = !pend[0].v || g == 0;
            m_r1 = !pend[1].v || g == 1;
            check("rnd_we",   write_enable,   32'(g >= 0));
            check("rnd_addr", write_address,  (g >= 0) ? 32'(pend[g].a) : 32'd0);
            check("rnd_data", write_data,     (g >= 0) ? pend[g].d : 32'd0);
            check("rnd_busy", busy_mask,      e_busy);
            check("rnd_r0",   wb0_ready,      32'(m_r0));
            check("rnd_r1",   wb1_ready,      32'(m_r1));
            check("rnd_cc",   conflict_count, 32'(m_cc));
            if (write_enable) dut_rf[write_address] = write_data;

            dv0 = (c < 2990) && ($urandom_range(0, 3) != 0);
            dv1 = (c < 2990) && ($urandom_range(0, 3) != 0);
            da0 = 5'($urandom_range(0, 7));
            da1 = 5'($urandom_range(0, 7));
            dd0 = $urandom;
            dd1 = $urandom;
            wb0_valid = dv0; wb0_address = da0; wb0_data = dd0;
            wb1_valid = dv1; wb1_address = da1; wb1_data = dd1;

            if (pend[0].v && pend[1].v && m_cc < 65535) m_cc++;
            if (g >= 0) begin
                pend[g].v = 0;
                m_prio = (g == 0);
            end
            if (dv0 && m_r0 && da0 != 0) begin
                pend[0] = '{1, da0, dd0, seq_ctr};
                seq_ctr++;
                last_val[da0] = dd0;
            end
            if (dv1 && m_r1 && da1 != 0) begin
                pend[1] = '{1, da1, dd1, seq_ctr};
                seq_ctr++;
                last_val[da1] = dd1;
            end
        end
        idle_inputs();
        for (int r = 0; r < 8; r++)
            check($sformatf("rnd_final_x%0d", r), dut_rf[r], last_val[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of write data.
REQ-002 Parameter: ADDR_WIDTH, 5, width of register address (32 registers, x0 hardwired zero).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 wb0_valid / wb0_ready  in / out  1 / 1  requester 0 (ALU writeback) handshake.
REQ-006 wb0_address / wb0_data  in  ADDR_WIDTH / DATA_WIDTH  requester 0 destination register and value.
REQ-007 wb1_valid / wb1_ready  in / out  1 / 1  requester 1 (load-unit writeback) handshake.
REQ-008 wb1_address / wb1_data  in  ADDR_WIDTH / DATA_WIDTH  requester 1 destination register and value.
REQ-009 write_enable / write_address / write_data  out  1 / ADDR_WIDTH / DATA_WIDTH  register file write port.
REQ-010 busy_mask  out  32  bit r = 1 while a buffered write to register r is pending.
REQ-011 conflict_count  out  16  saturating count of cycles where both buffers were full.

Function
REQ-012 Each requester SHALL own a one-entry buffer (valid, address, data, age bit); transfer occurs at posedge when valid && ready.
REQ-013 wbN_ready SHALL be 1 when buffer N is empty or buffer N is granted in the current cycle (back-to-back accept, one transfer per cycle per requester).
REQ-014 A transfer with address 0 SHALL be accepted and discarded: buffer not loaded, no write_enable, busy_mask unchanged.
REQ-015 write_enable SHALL be 1 iff at least one buffer is valid; write_address/write_data SHALL come combinationally from the granted buffer; 0 when write_enable is 0.
REQ-016 Latency: value accepted at edge N SHALL be written into the register file at edge N+1 when uncontended, N+2 when it loses arbitration once.
REQ-017 Only one buffer valid: that buffer SHALL be granted.
REQ-018 Both valid, different addresses: grant the requester indicated by priority bit prio; after any grant to requester k, prio <= 1-k.
REQ-019 Both valid, same address: grant the older entry regardless of prio; entries accepted in the same cycle treat requester 0 as older; prio still updates per REQ-018.
REQ-020 A granted buffer SHALL clear at the grant edge unless reloaded by a simultaneous transfer, in which case it holds the new entry marked younger than the other buffer.
REQ-021 busy_mask SHALL be the OR of one-hot decodes of valid buffer addresses; bit 0 always 0; combinational from buffer state.
REQ-022 conflict_count SHALL increment each cycle both buffers are valid, saturating at 16'hFFFF.
REQ-023 Requester inputs SHALL be ignored while wbN_valid is 0; no combinational path from wbN_valid to wbN_ready.

Reset
REQ-024 reset_n low SHALL asynchronously clear both buffers, set prio=0, conflict_count=0; outputs: write_enable=0, write_address=0, write_data=0, busy_mask=0, wb0_ready=wb1_ready=1.
REQ-025 Reset asserted mid-operation SHALL discard pending writes; no write_enable on the first edge after release.

Verification
REQ-026 Single write: wb0 {x5, 0x1234} at edge 1 -> edge 2 write_enable=1, addr 5, data 0x1234; busy_mask=0x20 between edges 1 and 2.
REQ-027 Contention, different addresses: wb0 {x3,0xA}, wb1 {x4,0xB} same edge after reset -> x3 written first, x4 next; conflict_count=1.
REQ-028 Same-address ordering: wb1 {x7,0x1} edge 1 (contended), wb0 {x7,0x2} edge 2 -> x7 receives 0x1 then 0x2, final value 0x2.
REQ-029 x0 drop: wb0 {x0,0xFFFFFFFF} -> accepted, ready stays 1, no write_enable, busy_mask=0.
REQ-030 Streaming: both requesters valid every cycle for 100 cycles -> alternating grants, one write per cycle, no lost or duplicated entries.
REQ-031 Reset mid-flight: both buffers full, reset_n pulsed low between edges -> outputs zero immediately, nothing written after release.
